// File: rtl/compare_pkg.sv
// Shared types and helpers for the chunked sequential comparator:
// branch codes, FSM states, chunk count and result decoding.
package compare_pkg;

  typedef enum logic [2:0] {
    F_EQ  = 3'b000,
    F_NE  = 3'b001,
    F_LT  = 3'b100,
    F_GE  = 3'b101,
    F_LTU = 3'b110,
    F_GEU = 3'b111
  } funct3_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SCAN,
    S_DONE
  } state_e;

  function automatic int nch(input int width, input int chunk);
    return width / chunk;
  endfunction

  // 010 and 011 are the only unused branch encodings
  function automatic logic is_valid_code(input logic [2:0] f);
    return f[2:1] != 2'b01;
  endfunction

  function automatic logic is_signed_code(input logic [2:0] f);
    return f[2:1] == 2'b10;
  endfunction

  function automatic logic flag_of(input logic [2:0] f, input logic lt, input logic eq);
    case (f)
      F_EQ:          return eq;
      F_NE:          return !eq;
      F_LT, F_LTU:   return lt;
      F_GE, F_GEU:   return !lt;
      default:       return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/chunk_cmp.sv
// Unsigned less-than / equality of one CHUNK-wide slice of the operands.
module chunk_cmp #(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  output logic             lt,
  output logic             eq
);

  assign lt = a < b;
  assign eq = a == b;

endmodule

// File: rtl/seq_compare.sv
// Multi-cycle RISC-V branch comparator: scans the operands CHUNK bits per cycle
// from the MSB end and stops at the first differing chunk.
module seq_compare
  import compare_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       funct3,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             flag,
  output logic             busy
);

  localparam int NCH = nch(WIDTH, CHUNK);
  localparam int KW  = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(NCH - 1);

  generate
    if (WIDTH % CHUNK != 0) begin : g_bad_chunk
      $error("seq_compare: WIDTH must be a multiple of CHUNK");
    end
  endgenerate

  state_e           state;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [2:0]       funct3_q;
  logic [KW-1:0]    k;
  logic             lt_q;
  logic             eq_q;

  logic [31:0]      shamt;
  logic [CHUNK-1:0] a_chunk;
  logic [CHUNK-1:0] b_chunk;
  logic             chunk_lt;
  logic             chunk_eq;

  // Flipping both sign bits in the top chunk turns the unsigned compare into a signed one
  always_comb begin
    shamt   = 32'(k) * 32'(CHUNK);
    a_chunk = CHUNK'((a_q << shamt) >> (WIDTH - CHUNK));
    b_chunk = CHUNK'((b_q << shamt) >> (WIDTH - CHUNK));
    if (is_signed_code(funct3_q) && (k == '0)) begin
      a_chunk[CHUNK-1] = ~a_chunk[CHUNK-1];
      b_chunk[CHUNK-1] = ~b_chunk[CHUNK-1];
    end
  end

  chunk_cmp #(
    .CHUNK(CHUNK)
  ) u_chunk_cmp (
    .a (a_chunk),
    .b (b_chunk),
    .lt(chunk_lt),
    .eq(chunk_eq)
  );

  // Invalid codes finish in the first scan cycle so their latency matches a k = 0 exit
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_IDLE;
      k     <= '0;
      lt_q  <= 1'b0;
      eq_q  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid && in_ready) begin
            a_q      <= a;
            b_q      <= b;
            funct3_q <= funct3;
            k        <= '0;
            state    <= S_SCAN;
          end
        end
        S_SCAN: begin
          if (!is_valid_code(funct3_q)) begin
            lt_q  <= 1'b0;
            eq_q  <= 1'b0;
            state <= S_DONE;
          end else if (!chunk_eq || (k == K_LAST)) begin
            lt_q  <= chunk_lt;
            eq_q  <= chunk_eq;
            state <= S_DONE;
          end else begin
            k <= k + 1'b1;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            k     <= '0;
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = (state == S_IDLE);
  assign out_valid = (state == S_DONE);
  assign busy      = (state != S_IDLE);
  assign flag      = out_valid && flag_of(funct3_q, lt_q, eq_q);

endmodule
